// File: rtl/gcd_job_scheduler_if.sv
// Control bundle between the GCD job scheduler, its requester agents and the
// shared GCD core. The scheduler connects through the master modport; the
// requesters/core side (or a bench standing in for them) through slave.
//
// Handshake: REQ[i] is a level request. A requester holds REQ[i], with its
// REQ_OPCODE slice and REQ_CT bit stable, until GNT[i] pulses for one cycle,
// and drops it in the following cycle. The scheduler looks at REQ only while
// idle. GNT, JOB_DONE, JOB_ERR and START_PULSE are single-cycle pulses with
// no back-pressure. DONE_PULSE from the core is a single-cycle pulse honoured
// only while a job is running. STATE_DBG mirrors the scheduler's FSM state.
interface gcd_job_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    REQ;
    logic [12*NUM_REQ-1:0] REQ_OPCODE;
    logic [NUM_REQ-1:0]    REQ_CT;
    logic [NUM_REQ-1:0]    GNT;
    logic [NUM_REQ-1:0]    JOB_DONE;
    logic [NUM_REQ-1:0]    JOB_ERR;
    logic                  START_PULSE;
    logic [11:0]           OPCODE;
    logic                  CONSTANT_TIME;
    logic                  DONE_PULSE;
    logic                  BUSY;
    logic [11:0]           CYCLE_COUNT;
    logic [1:0]            STATE_DBG;

    modport master (
        input  REQ, REQ_OPCODE, REQ_CT, DONE_PULSE,
        output GNT, JOB_DONE, JOB_ERR, START_PULSE, OPCODE, CONSTANT_TIME,
               BUSY, CYCLE_COUNT, STATE_DBG
    );

    modport slave (
        output REQ, REQ_OPCODE, REQ_CT, DONE_PULSE,
        input  GNT, JOB_DONE, JOB_ERR, START_PULSE, OPCODE, CONSTANT_TIME,
               BUSY, CYCLE_COUNT, STATE_DBG
    );
endinterface

// File: rtl/gcd_job_scheduler.sv
// Round-robin job scheduler in front of the shared GCD core. Picks one
// pending requester while idle, launches its opcode/mode with a start pulse,
// waits for the core's done pulse (or aborts after TIMEOUT run cycles) and
// returns a per-requester completion or error pulse.
module gcd_job_scheduler #(
    parameter int          NUM_REQ = 4,
    parameter logic [11:0] TIMEOUT = 12'd4000
) (
    input  logic                CLK,
    input  logic                RESETn,
    gcd_job_scheduler_if.master bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        RETIRE = 2'd3
    } state_t;

    state_t state;
    state_t state_nx;

    logic [IW-1:0]      ptr;
    logic [IW-1:0]      cur_idx;
    logic [IW-1:0]      hi_idx;
    logic [IW-1:0]      lo_idx;
    logic [IW-1:0]      win_idx;
    logic               hi_found;
    logic               lo_found;
    logic               win_found;
    logic [11:0]        win_op;
    logic               win_ct;
    logic [NUM_REQ-1:0] win_onehot;
    logic [NUM_REQ-1:0] cur_onehot;
    logic [11:0]        run_cnt;
    logic [11:0]        run_cnt_inc;
    logic               timeout_hit;

    // Round-robin search: first request above the pointer, else first at or
    // below it, which is the same as scanning upward from ptr+1 with wrap.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (bus.REQ[j] && (IW'(j) > ptr) && !hi_found) begin
                hi_found = 1'b1;
                hi_idx   = IW'(j);
            end
            if (bus.REQ[j] && (IW'(j) <= ptr) && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = IW'(j);
            end
        end
        win_found = hi_found | lo_found;
        win_idx   = hi_found ? hi_idx : lo_idx;
    end

    // Select the winner's opcode/mode and build one-hot vectors for the
    // winner (grant) and the job in flight (done/error).
    always_comb begin
        win_op     = '0;
        win_ct     = 1'b0;
        win_onehot = '0;
        cur_onehot = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (IW'(j) == win_idx) begin
                win_op        = bus.REQ_OPCODE[12*j +: 12];
                win_ct        = bus.REQ_CT[j];
                win_onehot[j] = 1'b1;
            end
            cur_onehot[j] = (IW'(j) == cur_idx);
        end
    end

    // Run counter helpers; the increment saturates so the reported count can
    // never wrap.
    assign run_cnt_inc = (run_cnt == 12'hFFF) ? 12'hFFF : run_cnt + 12'd1;
    assign timeout_hit = (run_cnt == TIMEOUT - 12'd1);
    assign bus.STATE_DBG = state;

    // FSM state register.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state; a done pulse outside RUN is ignored and a done pulse
    // coinciding with the timeout still retires the job.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (win_found) state_nx = LAUNCH;
            LAUNCH:  state_nx = RUN;
            RUN:     if (bus.DONE_PULSE || timeout_hit) state_nx = RETIRE;
            RETIRE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Registered outputs and job context: pulses default low every cycle and
    // are raised only for the single cycle the FSM is in LAUNCH or RETIRE.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            ptr               <= IW'(NUM_REQ - 1);
            cur_idx           <= '0;
            run_cnt           <= '0;
            bus.GNT           <= '0;
            bus.JOB_DONE      <= '0;
            bus.JOB_ERR       <= '0;
            bus.START_PULSE   <= 1'b0;
            bus.OPCODE        <= '0;
            bus.CONSTANT_TIME <= 1'b0;
            bus.BUSY          <= 1'b0;
            bus.CYCLE_COUNT   <= '0;
        end else begin
            bus.GNT         <= '0;
            bus.JOB_DONE    <= '0;
            bus.JOB_ERR     <= '0;
            bus.START_PULSE <= 1'b0;
            bus.BUSY        <= (state_nx != IDLE);
            case (state)
                IDLE: begin
                    if (win_found) begin
                        cur_idx           <= win_idx;
                        bus.OPCODE        <= win_op;
                        bus.CONSTANT_TIME <= win_ct;
                        bus.GNT           <= win_onehot;
                        bus.START_PULSE   <= 1'b1;
                    end
                end
                LAUNCH: begin
                    run_cnt <= '0;
                end
                RUN: begin
                    run_cnt <= run_cnt_inc;
                    if (bus.DONE_PULSE) begin
                        bus.JOB_DONE    <= cur_onehot;
                        bus.CYCLE_COUNT <= run_cnt_inc;
                    end else if (timeout_hit) begin
                        bus.JOB_ERR     <= cur_onehot;
                        bus.CYCLE_COUNT <= run_cnt_inc;
                    end
                end
                RETIRE: begin
                    ptr <= cur_idx;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_job_scheduler.sv
// Bench for gcd_job_scheduler: directed scenarios followed by random job
// streams, with a round-robin reference model and a negedge monitor that pops
// expected grants and completions as the scheduler produces them.
module tb_gcd_job_scheduler;
    localparam int NUM_REQ = 4;
    localparam int TIMEOUT = 16;

    logic CLK;
    logic RESETn;

    gcd_job_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

    gcd_job_scheduler #(
        .NUM_REQ(NUM_REQ),
        .TIMEOUT(12'(TIMEOUT))
    ) dut (
        .CLK   (CLK),
        .RESETn(RESETn),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int total;
    int bad;
    // grant entry: {idx[3:0], ct, opcode[11:0]}; job entry: {idx[3:0], err, count[11:0]}
    logic [16:0] gnt_q[$];
    logic [16:0] job_q[$];

    // reference model state
    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] hold;
    logic [11:0]        req_op [NUM_REQ];
    logic [NUM_REQ-1:0] req_ct_v;
    int                 mptr;
    bit                 after_retire;
    logic [11:0]        last_op;
    logic               last_ct;
    bit                 prev_ret;

    logic [16:0]        mon_e;
    logic [NUM_REQ-1:0] mon_oh;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Next winner from the pending set: first requester after the last served
    // one, wrapping around.
    function automatic int pick(input logic [NUM_REQ-1:0] m, input int p);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (m[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_req();
        bus.REQ = pend;
        for (int i = 0; i < NUM_REQ; i++) begin
            bus.REQ_OPCODE[12*i +: 12] = req_op[i];
            bus.REQ_CT[i]              = req_ct_v[i];
        end
    endtask

    task automatic raise(input int i, input logic [11:0] op, input logic c);
        if (!pend[i]) begin
            pend[i]     = 1'b1;
            req_op[i]   = op;
            req_ct_v[i] = c;
        end
    endtask

    task automatic clear_model();
        pend     = '0;
        hold     = '0;
        req_ct_v = '0;
        for (int i = 0; i < NUM_REQ; i++) req_op[i] = '0;
        mptr     = NUM_REQ - 1;
        last_op  = '0;
        last_ct  = 1'b0;
        prev_ret = 1'b0;
        bus.DONE_PULSE = 1'b0;
        drive_req();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gnt"},   32'(bus.GNT), 0);
        chk({tag, "_done"},  32'(bus.JOB_DONE), 0);
        chk({tag, "_err"},   32'(bus.JOB_ERR), 0);
        chk({tag, "_start"}, 32'(bus.START_PULSE), 0);
        chk({tag, "_op"},    32'(bus.OPCODE), 0);
        chk({tag, "_ct"},    32'(bus.CONSTANT_TIME), 0);
        chk({tag, "_busy"},  32'(bus.BUSY), 0);
        chk({tag, "_ccnt"},  32'(bus.CYCLE_COUNT), 0);
    endtask

    // Idle cycles with optional stray done pulses; only called with nothing pending.
    task automatic idle_gap(input int n, input bit stray);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            bus.DONE_PULSE = stray && ($urandom_range(0, 1) == 1);
        end
        if (n > 0) after_retire = 1'b0;
    endtask

    // Wait for the next grant; returns the number of negedges it took.
    task automatic wait_grant(output int n, output bit seen);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 4) begin
            @(negedge CLK);
            n++;
            seen = (bus.GNT != '0);
        end
    endtask

    // One job: predict the winner, wait for its grant, run the core for
    // run_len cycles (no done pulse when run_len exceeds TIMEOUT), wait for
    // the completion. stray_launch raises DONE_PULSE during the LAUNCH cycle.
    task automatic do_job(input int run_len, input bit stray_launch);
        int w;
        int n;
        int k;
        int cnt;
        bit seen;
        bit err;
        bus.DONE_PULSE = 1'b0;
        drive_req();
        w = pick(pend, mptr);
        if (w < 0) return;
        err = (run_len > TIMEOUT);
        cnt = err ? TIMEOUT : run_len;
        gnt_q.push_back({4'(w), req_ct_v[w], req_op[w]});
        job_q.push_back({4'(w), err, 12'(cnt)});
        mptr = w;
        wait_grant(n, seen);
        chk("grant_latency", 32'(n), after_retire ? 2 : 1);
        if (!seen) begin
            gnt_q.delete();
            job_q.delete();
            after_retire = 1'b0;
            return;
        end
        if (!hold[w]) pend[w] = 1'b0;
        drive_req();
        bus.DONE_PULSE = stray_launch;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < TIMEOUT + 4) begin
            @(negedge CLK);
            k++;
            seen = ((bus.JOB_DONE | bus.JOB_ERR) != '0);
            bus.DONE_PULSE = !seen && (k == run_len);
        end
        chk("done_latency", 32'(k), 32'(cnt + 1));
        if (!seen) job_q.delete();
        bus.DONE_PULSE = 1'b0;
        after_retire = 1'b1;
    endtask

    // Reset pulse while idle between scenarios.
    task automatic pulse_reset();
        @(negedge CLK);
        #2 RESETn = 1'b0;
        clear_model();
        @(negedge CLK);
        RESETn = 1'b1;
        after_retire = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(negedge CLK) begin
        if (RESETn === 1'b1) begin
            if (prev_ret) chk("busy_after_retire", 32'(bus.BUSY), 0);
            prev_ret = 1'b0;
            if (bus.GNT != '0 || bus.START_PULSE) begin
                if (gnt_q.size() == 0) begin
                    chk("grant_unexpected", 32'({bus.START_PULSE, bus.GNT}), 0);
                end else begin
                    mon_e  = gnt_q.pop_front();
                    mon_oh = NUM_REQ'(1) << mon_e[16:13];
                    chk("gnt",         32'(bus.GNT), 32'(mon_oh));
                    chk("start",       32'(bus.START_PULSE), 1);
                    chk("opcode",      32'(bus.OPCODE), 32'(mon_e[11:0]));
                    chk("ct",          32'(bus.CONSTANT_TIME), 32'(mon_e[12]));
                    chk("busy_launch", 32'(bus.BUSY), 1);
                    last_op = mon_e[11:0];
                    last_ct = mon_e[12];
                end
            end else begin
                chk("opcode_hold", 32'({bus.CONSTANT_TIME, bus.OPCODE}), 32'({last_ct, last_op}));
            end
            if ((bus.JOB_DONE | bus.JOB_ERR) != '0) begin
                if (job_q.size() == 0) begin
                    chk("job_unexpected", 32'({bus.JOB_ERR, bus.JOB_DONE}), 0);
                end else begin
                    mon_e  = job_q.pop_front();
                    mon_oh = NUM_REQ'(1) << mon_e[16:13];
                    chk("job_done",    32'(bus.JOB_DONE), mon_e[12] ? 0 : 32'(mon_oh));
                    chk("job_err",     32'(bus.JOB_ERR),  mon_e[12] ? 32'(mon_oh) : 0);
                    chk("cycle_count", 32'(bus.CYCLE_COUNT), 32'(mon_e[11:0]));
                    chk("busy_retire", 32'(bus.BUSY), 1);
                    prev_ret = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int sel;
        int len;
        bit seen;
        int w;
        total        = 0;
        bad          = 0;
        after_retire = 1'b0;
        RESETn       = 1'b0;
        clear_model();
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RESETn = 1'b1;

        // single job from requester 1, done 5 cycles after start
        raise(1, 12'h0A5, 1'b1);
        do_job(5, 1'b0);
        idle_gap(2, 1'b0);

        // all four requesters held high: strict rotation starting at 0
        pulse_reset();
        hold = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) raise(i, 12'($urandom), 1'($urandom_range(0, 1)));
        for (int i = 0; i < 5; i++) do_job(3, 1'b0);
        hold = '0;
        pend = '0;
        drive_req();
        idle_gap(2, 1'b0);

        // timeout, done on the last allowed cycle, one cycle short of timeout
        raise(2, 12'h3C7, 1'b0);
        do_job(TIMEOUT + 4, 1'b0);
        raise(3, 12'h111, 1'b1);
        do_job(TIMEOUT, 1'b0);
        raise(0, 12'hFFF, 1'b0);
        do_job(TIMEOUT - 1, 1'b0);
        raise(1, 12'h001, 1'b1);
        do_job(1, 1'b0);

        // stray done pulses while idle and during launch
        idle_gap(4, 1'b1);
        raise(0, 12'h5A5, 1'b1);
        do_job(4, 1'b1);
        idle_gap(1, 1'b0);

        // reset in the middle of a running job, then pointer back to 0
        raise(2, 12'h777, 1'b1);
        bus.DONE_PULSE = 1'b0;
        drive_req();
        w = pick(pend, mptr);
        gnt_q.push_back({4'(w), req_ct_v[w], req_op[w]});
        wait_grant(n, seen);
        chk("grant_latency_rst", 32'(n), 1);
        if (!seen) gnt_q.delete();
        pend[w] = 1'b0;
        drive_req();
        repeat (3) @(negedge CLK);
        #2 RESETn = 1'b0;
        #1 check_reset_outputs("midrun_reset");
        clear_model();
        @(negedge CLK);
        RESETn = 1'b1;
        after_retire = 1'b0;
        raise(0, 12'h246, 1'b0);
        raise(3, 12'h9AB, 1'b1);
        do_job(2, 1'b0);
        do_job(2, 1'b0);

        // random job streams
        for (int it = 0; it < 60; it++) begin
            if (pend == '0) idle_gap($urandom_range(0, 3), 1'b1);
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(0, 2) == 0) raise(i, 12'($urandom), 1'($urandom_range(0, 1)));
            end
            if (pend == '0) raise($urandom_range(0, NUM_REQ - 1), 12'($urandom), 1'($urandom_range(0, 1)));
            sel = $urandom_range(0, 9);
            if (sel < 7)       len = $urandom_range(1, 6);
            else if (sel == 7) len = TIMEOUT - 1;
            else if (sel == 8) len = TIMEOUT;
            else               len = TIMEOUT + 1 + $urandom_range(0, 3);
            do_job(len, $urandom_range(0, 3) == 0);
        end

        pend = '0;
        drive_req();
        idle_gap(3, 1'b0);
        chk("queues_drained", 32'(gnt_q.size() + job_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gcd_job_scheduler.md
Name: gcd_job_scheduler

Overview:
Sequences the shared GCD core on behalf of NUM_REQ hardware requesters. Arbitrates pending jobs round-robin and launches the winner's opcode and mode into the core with a one-cycle start pulse. It then waits for the core's done pulse, or aborts on timeout, and returns a per-requester completion or error pulse. It sits between the requester agents and the core's START_PULSE/OPCODE/CONSTANT_TIME/DONE_PULSE control interface, in parallel with the software register path.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMEOUT, 12'd4000, RUN-state cycle limit before abort (1..4095)

Ports:
CLK  in  1  clock
RESETn  in  1  reset, asynchronous, active-low
REQ  in  NUM_REQ  per-requester job request, level
REQ_OPCODE  in  12*NUM_REQ  opcode for requester i at bits [12i+11:12i]
REQ_CT  in  NUM_REQ  constant-time mode bit per requester
GNT  out  NUM_REQ  one-hot, one-cycle pulse: job of requester i launched
JOB_DONE  out  NUM_REQ  one-hot, one-cycle pulse: job of requester i completed
JOB_ERR  out  NUM_REQ  one-hot, one-cycle pulse: job of requester i timed out
START_PULSE  out  1  one-cycle start to the core
OPCODE  out  12  latched opcode to the core
CONSTANT_TIME  out  1  latched mode to the core
DONE_PULSE  in  1  core completion pulse
BUSY  out  1  high while not IDLE
CYCLE_COUNT  out  12  RUN-cycle count of the last retired job

Behaviour:
- All outputs are registered. Reset values: GNT, JOB_DONE, JOB_ERR = 0; START_PULSE = 0; OPCODE = 0; CONSTANT_TIME = 0; BUSY = 0; CYCLE_COUNT = 0. State resets to IDLE. The round-robin pointer resets to NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE -> LAUNCH -> RUN -> RETIRE -> IDLE.
- IDLE:
  - REQ is sampled only in IDLE.
  - If REQ is nonzero, the winner is the first set bit searching upward from pointer+1, wrapping modulo NUM_REQ.
  - Latch the winner index, REQ_OPCODE slice and REQ_CT; next state is LAUNCH.
  - A REQ bit deasserted before being sampled is simply not considered.
- LAUNCH (one cycle):
  - START_PULSE = 1 and GNT[w] = 1 for this cycle only.
  - OPCODE/CONSTANT_TIME show the latched values from this cycle on. They are held stable until the next LAUNCH.
  - The run counter is cleared to 0. Next state is RUN.
- RUN:
  - The counter increments once per cycle spent in RUN.
  - If DONE_PULSE = 1: next state RETIRE with status OK.
  - Else if counter == TIMEOUT-1: next state RETIRE with status ERR.
  - If DONE_PULSE and the timeout condition occur in the same cycle, DONE wins (status OK).
- RETIRE (one cycle):
  - JOB_DONE[w] = 1 if status OK, JOB_ERR[w] = 1 if status ERR; never both.
  - CYCLE_COUNT is loaded with the RUN cycle count, counting the cycle in which DONE_PULSE or the timeout occurred. This is 1..TIMEOUT, saturating at 4095.
  - pointer <= w; BUSY drops on the next cycle; next state IDLE.
- DONE_PULSE in IDLE, LAUNCH or RETIRE is ignored. It does not affect state or outputs.
- Latency:
  - REQ sampled in IDLE cycle t gives GNT/START_PULSE at t+1.
  - DONE_PULSE at cycle d gives JOB_DONE at d+1. The earliest new grant is d+3 (IDLE at d+2, LAUNCH at d+3).
- Requester protocol:
  - REQ should be dropped in the cycle after GNT.
  - If REQ is still high when the scheduler returns to IDLE, it is treated as a new job.
  - Fairness: a requester that holds REQ waits for at most NUM_REQ-1 other jobs.
- Reset mid-operation: asynchronous return to IDLE with all outputs at their reset values. The in-flight job is dropped and gets no JOB_DONE/JOB_ERR. The core is not notified; the core shares the same reset.
- BUSY = 1 in LAUNCH, RUN and RETIRE.

Test Plan:
1. Single job: NUM_REQ=4. REQ=4'b0010, REQ_OPCODE[23:12]=12'h0A5, REQ_CT[1]=1; DONE_PULSE 5 cycles after START_PULSE -> GNT=4'b0010 one cycle with START_PULSE, OPCODE=0x0A5, CONSTANT_TIME=1; JOB_DONE=4'b0010 one cycle later; CYCLE_COUNT=5.
2. Round-robin: REQ=4'b1111 held continuously, DONE after 3 cycles each -> grant order 0, 1, 2, 3, 0. No JOB_ERR.
3. Timeout: TIMEOUT=16, no DONE_PULSE -> JOB_ERR[w] pulse, JOB_DONE=0, CYCLE_COUNT=16, BUSY low 2 cycles after the abort.
4. Simultaneous: DONE_PULSE in the same cycle that the counter hits TIMEOUT-1 -> JOB_DONE pulse, JOB_ERR=0, CYCLE_COUNT=TIMEOUT.
5. Stray done: DONE_PULSE while IDLE and during LAUNCH -> no state change, no JOB_DONE. The job completes only on the next in-RUN DONE_PULSE.
6. Reset in RUN: assert RESETn=0 mid-job -> all outputs 0 immediately. After release, REQ=4'b1001 grants requester 0 first.
